// File: rtl/reset_sequencer_if.sv
// Handshake bundle between the reset sequencer and its surroundings:
// restart request and per-stage ready in, per-stage resets and status out.
interface reset_sequencer_if #(
  parameter int STAGES = 3
) ();
  logic              req;
  logic [STAGES-1:0] ready;
  logic [STAGES-1:0] rst_out;
  logic              done;
  logic              fault;

  modport master (
    output req,
    output ready,
    input  rst_out,
    input  done,
    input  fault
  );

  modport slave (
    input  req,
    input  ready,
    output rst_out,
    output done,
    output fault
  );
endinterface

// File: rtl/reset_sequencer.sv
// Releases STAGES reset domains in order, with a hold period, an inter-stage
// gap and a bounded wait for each stage's ready; faults on timeout or ready loss.
module reset_sequencer #(
  parameter int STAGES  = 3,
  parameter int HOLD    = 16,
  parameter int GAP     = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  reset_sequencer_if.slave bus
);

  localparam int MAX_HG = (HOLD > GAP) ? HOLD : GAP;
  localparam int MAX_N  = (MAX_HG > TIMEOUT) ? MAX_HG : TIMEOUT;
  localparam int CNT_W  = $clog2(MAX_N + 1);
  localparam int STG_W  = (STAGES > 1) ? $clog2(STAGES) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);
  localparam logic [STG_W-1:0] LAST_STAGE = STG_W'(STAGES - 1);

  localparam logic [2:0] ST_HOLD  = 3'd0;
  localparam logic [2:0] ST_GAP   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_FAULT = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [STG_W-1:0]  stage_q, stage_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STAGES-1:0] rst_out_q, rst_out_d;
  logic              done_q, done_d;
  logic              fault_q, fault_d;
  logic [STAGES-1:0] released;

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    case (state_q)
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        // A ready seen on the last allowed cycle wins over the timeout.
        if (bus.ready[stage_q]) begin
          cnt_d = '0;
          if (stage_q == LAST_STAGE) begin
            state_d = ST_RUN;
          end else begin
            stage_d = stage_q + 1'b1;
            state_d = ST_GAP;
          end
        end else if (cnt_q == TO_LAST) begin
          state_d = ST_FAULT;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (!(&bus.ready)) begin
          state_d = ST_FAULT;
          cnt_d   = '0;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_FAULT;
        cnt_d   = '0;
      end
    endcase

    if (bus.req) begin
      state_d = ST_HOLD;
      stage_d = '0;
      cnt_d   = '0;
    end
  end

  // Outputs follow the current state one edge later; a restart forces them at once.
  always_comb begin
    released = '0;
    for (int i = 0; i < STAGES; i++) begin
      released[i] = (state_q == ST_RUN) ||
                    ((state_q == ST_GAP)  && (STG_W'(i) <  stage_q)) ||
                    ((state_q == ST_WAIT) && (STG_W'(i) <= stage_q));
    end
    rst_out_d = ~released;
    done_d    = (state_q == ST_RUN);
    fault_d   = (state_q == ST_FAULT);
    if (bus.req) begin
      rst_out_d = '1;
      done_d    = 1'b0;
      fault_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_HOLD;
      stage_q   <= '0;
      cnt_q     <= '0;
      rst_out_q <= '1;
      done_q    <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      cnt_q     <= cnt_d;
      rst_out_q <= rst_out_d;
      done_q    <= done_d;
      fault_q   <= fault_d;
    end
  end

  assign bus.rst_out = rst_out_q;
  assign bus.done    = done_q;
  assign bus.fault   = fault_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed bring-up scenarios plus random
// ready/req/rst traffic, compared every cycle against a timeline model.
module tb_reset_sequencer;

  localparam int S  = 3;
  localparam int HD = 4;
  localparam int GP = 2;
  localparam int TO = 8;

  logic clk;
  logic rst;

  reset_sequencer_if #(.STAGES(S)) bus ();

  reset_sequencer #(
    .STAGES (S),
    .HOLD   (HD),
    .GAP    (GP),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: sequence mode, current stage k, and the edge rel at which stage k
  // is let go internally; its wait window is edges rel+1 .. rel+TO.
  int        m_mode;   // 0 sequencing, 1 running, 2 faulted
  int        m_k;
  int        m_rel;
  int        n_edge = 0;
  logic [S-1:0] v_rst;
  logic      v_done;
  logic      v_fault;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, n_edge, got, exp);
    end
  endtask

  task automatic model_view();
    v_rst   = '1;
    v_done  = 1'b0;
    v_fault = 1'b0;
    if (m_mode == 1) begin
      v_rst  = '0;
      v_done = 1'b1;
    end else if (m_mode == 2) begin
      v_fault = 1'b1;
    end else begin
      for (int i = 0; i < S; i++)
        if (i < m_k || (i == m_k && n_edge >= m_rel)) v_rst[i] = 1'b0;
    end
  endtask

  task automatic step();
    logic [S-1:0] e_rst;
    logic         e_done;
    logic         e_fault;
    logic [S-1:0] rdy;
    @(posedge clk);
    n_edge++;
    rdy = bus.ready;
    if (rst || bus.req) begin
      e_rst   = '1;
      e_done  = 1'b0;
      e_fault = 1'b0;
      m_mode  = 0;
      m_k     = 0;
      m_rel   = n_edge + HD + GP;
    end else begin
      e_rst   = v_rst;
      e_done  = v_done;
      e_fault = v_fault;
      if (m_mode == 0) begin
        if (n_edge > m_rel && n_edge <= m_rel + TO) begin
          if (rdy[m_k]) begin
            if (m_k == S - 1) m_mode = 1;
            else begin
              m_k   = m_k + 1;
              m_rel = n_edge + GP;
            end
          end else if (n_edge == m_rel + TO) begin
            m_mode = 2;
          end
        end
      end else if (m_mode == 1) begin
        if (rdy != '1) m_mode = 2;
      end
    end
    model_view();
    #1;
    check("rst_out", 32'(bus.rst_out), 32'(e_rst));
    check("done",    32'(bus.done),    32'(e_done));
    check("fault",   32'(bus.fault),   32'(e_fault));
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    bus.req = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  initial begin
    rst       = 1'b1;
    bus.req   = 1'b0;
    bus.ready = '1;
    m_mode    = 0;
    m_k       = 0;
    m_rel     = 0;
    v_rst     = '1;
    v_done    = 1'b0;
    v_fault   = 1'b0;

    // Clean bring-up with everything ready.
    do_reset();
    bus.ready = 3'b111;
    run(20);

    // Stage 1 never locks: timeout, then stays faulted until a restart.
    do_reset();
    bus.ready = 3'b101;
    run(30);
    bus.req = 1'b1; step(); bus.req = 1'b0;
    bus.ready = 3'b111;
    run(20);

    // Restart while stage 1 is in its gap.
    do_reset();
    run(8);
    bus.req = 1'b1; step(); bus.req = 1'b0;
    run(20);

    // Single-cycle ready drop while running.
    do_reset();
    run(18);
    bus.ready = 3'b110; step(); bus.ready = 3'b111;
    run(6);
    bus.req = 1'b1; step(); bus.req = 1'b0;
    run(18);

    // Stage 2 ready arriving on the last allowed wait cycle, then one cycle too late.
    for (int late = 19; late <= 20; late++) begin
      do_reset();
      for (int e = 0; e < 26; e++) begin
        bus.ready = (e >= late) ? 3'b111 : 3'b011;
        step();
      end
    end

    // rst and req together during stage 2 wait, then a normal bring-up.
    do_reset();
    bus.ready = 3'b011;
    run(14);
    rst = 1'b1; bus.req = 1'b1; step();
    rst = 1'b0; bus.req = 1'b0;
    bus.ready = 3'b111;
    run(20);

    // Random traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      bus.req   = ($urandom_range(0, 99) == 0);
      bus.ready = ($urandom_range(0, 99) < 85) ? 3'b111 : 3'($urandom_range(0, 7));
      step();
    end
    rst     = 1'b0;
    bus.req = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
